touch_adc_spi_ctrl: RTL

Avalon-MM slave that drives the touch panel's serial 12-bit ADC (ADS7843-style) and returns X/Y pen coordinates. It sits directly upstream of the pen-IRQ PIO and shares the same pen_irq_n pin. This block converts the pen-down condition into coordinate samples, which the CPU reads after the PIO edge interrupt or after this block's own data-ready interrupt.

---
 rtl/touch_adc_spi_ctrl_if.sv | 20 ++
 rtl/touch_adc_spi_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_adc_spi_ctrl_if.sv
// Avalon-MM slave bus bundle for touch_adc_spi_ctrl.
// master: the CPU-side bridge; slave: the touch ADC controller.
interface touch_adc_spi_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/touch_adc_spi_ctrl.sv
// Touch panel ADC controller (ADS7843-style serial 12-bit ADC) with Avalon-MM slave.
// Runs one X/Y frame pair per conversion, on a start write or while the pen is down
// with auto-repeat enabled.
// Build option: define TP_AVERAGE_EN to run 4 frame pairs per conversion and report
// the truncated mean of the four X and four Y samples.
module touch_adc_spi_ctrl #(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned GAP_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset_n,
  touch_adc_spi_ctrl_if.slave bus,
  input  logic                pen_irq_n,
  output logic                adc_cs_n,
  output logic                adc_dclk,
  output logic                adc_din,
  input  logic                adc_dout
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [7:0] CmdX = 8'hD0;
  localparam logic [7:0] CmdY = 8'h90;
  // 24 DCLK periods = 48 half-periods per frame
  localparam logic [5:0] LastHalf = 6'd47;

`ifdef TP_AVERAGE_EN
  localparam int unsigned AccW = 14;
  logic [1:0] pair_q, pair_d;
`else
  localparam int unsigned AccW = 12;
`endif

  typedef enum logic [2:0] {
    StIdle, StSetup, StXferX, StXferY, StHold, StDone, StGap
  } state_e;

  state_e state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [5:0]      half_q, half_d;
  logic            dclk_q, dclk_d;
  logic            din_q, din_d;
  logic            cs_n_q, cs_n_d;
  logic [11:0]     shift_q, shift_d;
  logic [AccW-1:0] x_acc_q, x_acc_d, y_acc_q, y_acc_d;
  logic [11:0]     x_q, x_d, y_q, y_d;
  logic            data_valid_q, data_valid_d;
  logic            auto_en_q, auto_en_d;
  logic            irq_en_q, irq_en_d;
  logic            start_q, start_d;
  logic [31:0]     readdata_q, readdata_d;
  logic            pen_s1_q, pen_s2_q;

  logic        pen_down, busy, tick, wr_en, rd_en;
  logic [4:0]  kidx;
  logic [7:0]  cmd;
  logic [11:0] rpt_x, rpt_y;
  logic        unused_wdata;

  assign unused_wdata = ^bus.writedata[31:3];

  // Two-flop synchroniser for the asynchronous pen interrupt pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pen_s1_q <= 1'b0;
      pen_s2_q <= 1'b0;
    end else begin
      pen_s1_q <= pen_irq_n;
      pen_s2_q <= pen_s1_q;
    end
  end

  assign pen_down = ~pen_s2_q;
  assign busy     = (state_q != StIdle);
  assign tick     = (div_q == DivW'(CLK_DIV - 1));
  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign rd_en    = bus.chipselect & bus.write_n;
  // kidx = k-1 for the DCLK period currently in progress
  assign kidx     = half_q[5:1];
  assign cmd      = (state_q == StXferX) ? CmdX : CmdY;

`ifdef TP_AVERAGE_EN
  assign rpt_x = x_acc_q[13:2];
  assign rpt_y = y_acc_q[13:2];
`else
  assign rpt_x = x_acc_q;
  assign rpt_y = y_acc_q;
`endif

  // Next-state logic: bus register file, FSM and serial engine
  always_comb begin
    state_d      = state_q;
    div_d        = '0;
    gap_d        = gap_q;
    half_d       = half_q;
    dclk_d       = dclk_q;
    din_d        = din_q;
    cs_n_d       = cs_n_q;
    shift_d      = shift_q;
    x_acc_d      = x_acc_q;
    y_acc_d      = y_acc_q;
    x_d          = x_q;
    y_d          = y_q;
    data_valid_d = data_valid_q;
    auto_en_d    = auto_en_q;
    irq_en_d     = irq_en_q;
    start_d      = 1'b0;
    readdata_d   = readdata_q;
`ifdef TP_AVERAGE_EN
    pair_d       = pair_q;
`endif

    if (wr_en && bus.address == 2'd2) begin
      auto_en_d = bus.writedata[0];
      irq_en_d  = bus.writedata[1];
      start_d   = bus.writedata[2];
    end
    if (wr_en && bus.address == 2'd3) data_valid_d = 1'b0;

    // Old X/Y are returned when a read coincides with the DONE latch
    if (rd_en) begin
      case (bus.address)
        2'd0:    readdata_d = {20'b0, x_q};
        2'd1:    readdata_d = {20'b0, y_q};
        2'd2:    readdata_d = {30'b0, irq_en_q, auto_en_q};
        default: readdata_d = {29'b0, pen_down, data_valid_q, busy};
      endcase
    end

    if (state_q inside {StSetup, StXferX, StXferY, StHold}) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        // Triggers arriving while busy are simply dropped
        if (start_q || (auto_en_q && pen_down)) begin
          state_d = StSetup;
          cs_n_d  = 1'b0;
          x_acc_d = '0;
          y_acc_d = '0;
`ifdef TP_AVERAGE_EN
          pair_d  = '0;
`endif
        end
      end
      StSetup: begin
        if (tick) begin
          state_d = StXferX;
          half_d  = '0;
          din_d   = CmdX[7];
        end
      end
      StXferX, StXferY: begin
        if (tick) begin
          if (!half_q[0]) begin
            // Rising edge: sample D11..D0 on k = 10..21
            dclk_d = 1'b1;
            half_d = half_q + 6'd1;
            if (kidx >= 5'd9 && kidx <= 5'd20) shift_d = {shift_q[10:0], adc_dout};
          end else begin
            // Falling edge: present the next command bit
            dclk_d = 1'b0;
            if (half_q == LastHalf) begin
              half_d = '0;
              if (state_q == StXferX) begin
`ifdef TP_AVERAGE_EN
                x_acc_d = x_acc_q + {2'b00, shift_q};
`else
                x_acc_d = shift_q;
`endif
                state_d = StXferY;
                din_d   = CmdY[7];
              end else begin
`ifdef TP_AVERAGE_EN
                y_acc_d = y_acc_q + {2'b00, shift_q};
                if (pair_q == 2'd3) begin
                  state_d = StHold;
                  din_d   = 1'b0;
                end else begin
                  pair_d  = pair_q + 2'd1;
                  state_d = StXferX;
                  din_d   = CmdX[7];
                end
`else
                y_acc_d = shift_q;
                state_d = StHold;
                din_d   = 1'b0;
`endif
              end
            end else begin
              half_d = half_q + 6'd1;
              din_d  = (kidx <= 5'd6) ? cmd[3'(5'd6 - kidx)] : 1'b0;
            end
          end
        end
      end
      StHold: begin
        if (tick) begin
          state_d = StDone;
          cs_n_d  = 1'b1;
        end
      end
      StDone: begin
        // Set overrides a same-cycle clear from the bus
        x_d          = rpt_x;
        y_d          = rpt_y;
        data_valid_d = 1'b1;
        gap_d        = '0;
        state_d      = auto_en_q ? StGap : StIdle;
      end
      StGap: begin
        if (gap_q == GapW'(GAP_CYCLES - 1)) state_d = StIdle;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any transfer without latching a result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      div_q        <= '0;
      gap_q        <= '0;
      half_q       <= '0;
      dclk_q       <= 1'b0;
      din_q        <= 1'b0;
      cs_n_q       <= 1'b1;
      shift_q      <= '0;
      x_acc_q      <= '0;
      y_acc_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      data_valid_q <= 1'b0;
      auto_en_q    <= 1'b0;
      irq_en_q     <= 1'b0;
      start_q      <= 1'b0;
      readdata_q   <= '0;
`ifdef TP_AVERAGE_EN
      pair_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      gap_q        <= gap_d;
      half_q       <= half_d;
      dclk_q       <= dclk_d;
      din_q        <= din_d;
      cs_n_q       <= cs_n_d;
      shift_q      <= shift_d;
      x_acc_q      <= x_acc_d;
      y_acc_q      <= y_acc_d;
      x_q          <= x_d;
      y_q          <= y_d;
      data_valid_q <= data_valid_d;
      auto_en_q    <= auto_en_d;
      irq_en_q     <= irq_en_d;
      start_q      <= start_d;
      readdata_q   <= readdata_d;
`ifdef TP_AVERAGE_EN
      pair_q       <= pair_d;
`endif
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_dclk     = dclk_q;
  assign adc_din      = din_q;
  assign bus.readdata = readdata_q;
  assign bus.irq      = data_valid_q & irq_en_q;

endmodule
